// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and helpers for the mux_scan_sel block.
//   MODE_MANUAL / MODE_SCAN : encodings of the 'mode' input
//   clog2()                 : ceiling log2, used to validate the select width
//   MUX_SCAN_STATIC_ASSERT  : elaboration-time parameter check macro
// Optional feature macro used by the top: MUX_SCAN_ONEHOT_EN.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Smallest n such that 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int n;
    n = 0;
    while ((32'sd1 <<< n) < value) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// Elaboration-time check: produces an $error in the generate scope if cond is false.
`ifndef MUX_SCAN_STATIC_ASSERT
`define MUX_SCAN_STATIC_ASSERT(cond, label) \
  if (!(cond)) begin : label \
    $error("mux_scan_sel: parameter check failed"); \
  end
`endif

// File: rtl/mux_scan_sel_prescaler.sv
// scan_prescaler: dwell counter for scan mode.
//   clk  : system clock
//   rst  : synchronous active-high reset (div_cnt -> 0)
//   clr  : forces div_cnt to 0 (driven while in manual mode)
//   hold : freezes div_cnt
//   tc   : advance strobe; high when div_cnt is at DIV-1 and neither clr nor hold
//          is asserted, i.e. the channel must step on this edge
module scan_prescaler #(
  parameter int DIV   = 4,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tc
);

  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             at_last_s;

  assign at_last_s = (div_cnt_r == LAST_CNT);
  // hold beats terminal count so a frozen scan never advances
  assign tc = at_last_s & ~clr & ~hold;

  // Dwell counter: clears on reset/manual, freezes on hold, wraps at DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (clr) begin
      div_cnt_r <= '0;
    end else if (hold) begin
      div_cnt_r <= div_cnt_r;
    end else if (at_last_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: N-channel, W-bit registered selector with manual and scan modes.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset, highest priority
//   mode    : 0 = manual (sel drives channel), 1 = scan (prescaler steps channel)
//   sel     : manual channel select
//   hold    : scan mode only, freezes prescaler and channel
//   din     : flattened inputs, channel k = din[k*WIDTH +: WIDTH]
//   o       : registered data of the registered channel (2 edges after sel)
//   cur_sel : registered current channel
//   tick    : one-cycle pulse on the edge cur_sel advances in scan mode
//   sel_err : registered, set when manual sel >= CH
//   an      : (only with MUX_SCAN_ONEHOT_EN) active-low one-hot of cur_sel,
//             updated together with o
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = 3,
  parameter int DIV   = 4,
  parameter int DIV_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                hold,
  input  logic [CH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]    o,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                tick,
  output logic                sel_err
`ifdef MUX_SCAN_ONEHOT_EN
  ,
  output logic [CH-1:0]       an
`endif
);

  `MUX_SCAN_STATIC_ASSERT(SEL_W >= clog2(CH), g_chk_sel_w)
  `MUX_SCAN_STATIC_ASSERT((DIV >= 1) && ((DIV_W >= 32) || (64'(DIV) < (64'd1 << DIV_W))), g_chk_div)

  localparam int                 NSLOT    = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(CH - 1);
  localparam logic [SEL_W:0]     CH_L     = (SEL_W + 1)'(CH);

  logic             manual_s;
  logic             advance_s;
  logic             sel_ok_s;
  logic [SEL_W-1:0] next_scan_s;
  logic [WIDTH-1:0] chan_s [NSLOT];

  // Unpopulated select codes (CH not a power of two) read as zero.
  for (genvar g = 0; g < NSLOT; g++) begin : g_chan
    if (g < CH) begin : g_used
      assign chan_s[g] = din[g*WIDTH +: WIDTH];
    end else begin : g_unused
      assign chan_s[g] = '0;
    end
  end

  assign manual_s    = (mode == MODE_MANUAL);
  assign sel_ok_s    = ({1'b0, sel} < CH_L);
  // wrap at CH-1 rather than at the select-width limit
  assign next_scan_s = (cur_sel == LAST_SEL) ? '0 : cur_sel + SEL_W'(1);

  scan_prescaler #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (manual_s),
    .hold (hold),
    .tc   (advance_s)
  );

  // Channel register, tick and select-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel <= '0;
      tick    <= 1'b0;
      sel_err <= 1'b0;
    end else if (manual_s) begin
      tick <= 1'b0;
      if (sel_ok_s) begin
        cur_sel <= sel;
        sel_err <= 1'b0;
      end else begin
        sel_err <= 1'b1;
      end
    end else begin
      sel_err <= 1'b0;
      tick    <= advance_s;
      if (advance_s) begin
        cur_sel <= next_scan_s;
      end
    end
  end

  // Output data register, indexed by the already-registered channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      o <= '0;
    end else begin
      o <= chan_s[cur_sel];
    end
  end

`ifdef MUX_SCAN_ONEHOT_EN
  // Active-low one-hot strobe, same timing as o.
  always_ff @(posedge clk) begin
    if (rst) begin
      an <= ~CH'(1'b1);
    end else begin
      an <= ~(CH'(1'b1) << cur_sel);
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_sel.sv
// tb_mux_scan_sel: scoreboard bench for mux_scan_sel.
// Two instances share stimulus: CH=8 and CH=6 (both SEL_W=3, DIV=4).
// A behavioural model computes the expected registered outputs for each edge,
// pushes them into per-instance queues, and they are popped and compared
// one time unit after the edge. Build with MUX_SCAN_ONEHOT_EN to also check 'an'.
module tb_mux_scan_sel;

  typedef struct packed {
    logic [2:0]  cur;
    logic [15:0] cnt;
    logic [7:0]  o;
    logic        tick;
    logic        err;
    logic [7:0]  an;
  } st_t;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [2:0]  sel;
  logic        hold;
  logic [63:0] din;
  logic [47:0] din6;

  logic [7:0]  o8, o6;
  logic [2:0]  cur8, cur6;
  logic        tick8, tick6;
  logic        err8, err6;
  logic [7:0]  an8;
  logic [5:0]  an6;

  int total;
  int bad;

  st_t m8, m6;
  st_t q8[$];
  st_t q6[$];

  assign din6 = din[47:0];

  mux_scan_sel #(.WIDTH(8), .CH(8), .SEL_W(3), .DIV(4), .DIV_W(16)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .sel     (sel),
    .hold    (hold),
    .din     (din),
    .o       (o8),
    .cur_sel (cur8),
    .tick    (tick8),
    .sel_err (err8)
`ifdef MUX_SCAN_ONEHOT_EN
    ,
    .an      (an8)
`endif
  );

  mux_scan_sel #(.WIDTH(8), .CH(6), .SEL_W(3), .DIV(4), .DIV_W(16)) u_dut6 (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .sel     (sel),
    .hold    (hold),
    .din     (din6),
    .o       (o6),
    .cur_sel (cur6),
    .tick    (tick6),
    .sel_err (err6)
`ifdef MUX_SCAN_ONEHOT_EN
    ,
    .an      (an6)
`endif
  );

  initial clk = 1'b0;
  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected state after one rising edge, from the state before it and the inputs.
  function automatic st_t next_st(input st_t s, input int ch, input logic r, input logic md,
                                  input logic [2:0] sl, input logic hd, input logic [63:0] dv);
    st_t n;
    n = s;
    if (r) begin
      n.cur = 3'd0; n.cnt = 16'd0; n.o = 8'h00; n.tick = 1'b0; n.err = 1'b0; n.an = 8'hFE;
    end else begin
      n.o  = dv[s.cur*8 +: 8];
      n.an = ~(8'd1 << s.cur);
      if (!md) begin
        n.cnt = 16'd0;
        n.tick = 1'b0;
        if (int'(sl) < ch) begin
          n.cur = sl; n.err = 1'b0;
        end else begin
          n.err = 1'b1;
        end
      end else begin
        n.err = 1'b0;
        if (hd) begin
          n.tick = 1'b0;
        end else if (s.cnt == 16'd3) begin
          n.cnt = 16'd0;
          n.tick = 1'b1;
          n.cur = (int'(s.cur) == ch - 1) ? 3'd0 : s.cur + 3'd1;
        end else begin
          n.cnt = s.cnt + 16'd1;
          n.tick = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // One clock edge: predict, push, wait, pop and compare both instances.
  task automatic cycle();
    st_t e8, e6;
    m8 = next_st(m8, 8, rst, mode, sel, hold, din);
    m6 = next_st(m6, 6, rst, mode, sel, hold, {16'h0000, din6});
    q8.push_back(m8);
    q6.push_back(m6);
    @(posedge clk);
    #1;
    e8 = q8.pop_front();
    e6 = q6.pop_front();
    chk("o8",    64'(o8),    64'(e8.o));
    chk("cur8",  64'(cur8),  64'(e8.cur));
    chk("tick8", 64'(tick8), 64'(e8.tick));
    chk("err8",  64'(err8),  64'(e8.err));
    chk("o6",    64'(o6),    64'(e6.o));
    chk("cur6",  64'(cur6),  64'(e6.cur));
    chk("tick6", 64'(tick6), 64'(e6.tick));
    chk("err6",  64'(err6),  64'(e6.err));
`ifdef MUX_SCAN_ONEHOT_EN
    chk("an8",   64'(an8),   64'(e8.an));
    chk("an6",   64'(an6),   64'(e6.an[5:0]));
`endif
  endtask

  initial begin
    int ticks;
    logic [2:0] saved;
    total = 0;
    bad   = 0;
    m8 = '0;
    m6 = '0;
    rst = 1'b1; mode = 1'b0; sel = 3'd0; hold = 1'b0;
    din = 64'h7766_5544_3322_1100;

    // Reset
    cycle(); cycle();
    chk("rst_o", 64'(o8), 64'h00);

    // Manual sel=5: cur_sel after 1 edge, o after 2
    rst = 1'b0; sel = 3'd5;
    cycle();
    chk("man5_cur", 64'(cur8), 64'd5);
    cycle();
    chk("man5_o", 64'(o8), 64'h55);
`ifdef MUX_SCAN_ONEHOT_EN
    chk("man5_an", 64'(an8), 64'hDF);
`endif
    cycle();

    // Manual sweep 0..7, 5 cycles each (sel 6/7 out of range for CH=6)
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      for (int c = 0; c < 5; c++) cycle();
      chk("sweep_o", 64'(o8), 64'(s * 8'h11));
    end

    // Park at channel 0, then scan 32 edges: 8 ticks, full wrap
    sel = 3'd0;
    cycle(); cycle();
    mode = 1'b1;
    ticks = 0;
    for (int c = 0; c < 32; c++) begin
      cycle();
      if (tick8) ticks = ticks + 1;
    end
    chk("scan_ticks", 64'(ticks), 64'd8);
    chk("scan_wrap_cur", 64'(cur8), 64'd0);

    // Hold at div_cnt=3 for 10 edges, then release
    for (int c = 0; c < 8 && m8.cnt != 16'd3; c++) cycle();
    saved = m8.cur;
    hold = 1'b1;
    ticks = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (tick8) ticks = ticks + 1;
    end
    chk("hold_ticks", 64'(ticks), 64'd0);
    chk("hold_cur", 64'(cur8), 64'(saved));
    hold = 1'b0;
    cycle();
    chk("release_tick", 64'(tick8), 64'd1);
    chk("release_cur", 64'(cur8), 64'((saved == 3'd7) ? 3'd0 : saved + 3'd1));

    // Manual out-of-range for CH=6: sel_err set, o holds
    mode = 1'b0; sel = 3'd2;
    cycle(); cycle();
    sel = 3'd6;
    cycle(); cycle();
    chk("err6_flag", 64'(err6), 64'd1);
    chk("err6_o", 64'(o6), 64'h22);

    // Randomised mixed traffic
    for (int c = 0; c < 300; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      mode = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) din = {$urandom, $urandom};
      cycle();
    end

    // Reset mid-scan at cur_sel=4, then first tick 4 edges later
    rst = 1'b0; mode = 1'b1; hold = 1'b0;
    din = 64'h7766_5544_3322_1100;
    for (int c = 0; c < 80 && m8.cur != 3'd4; c++) cycle();
    chk("pre_rst_cur", 64'(cur8), 64'd4);
    rst = 1'b1;
    cycle();
    chk("midrst_cur", 64'(cur8), 64'd0);
    chk("midrst_o", 64'(o8), 64'h00);
    chk("midrst_tick", 64'(tick8), 64'd0);
`ifdef MUX_SCAN_ONEHOT_EN
    chk("midrst_an", 64'(an8), 64'hFE);
`endif
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("restart_tick", 64'(tick8), 64'(c == 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised N-channel, W-bit selector with a registered output and two modes. Manual mode selects a channel from an external select. Scan mode steps through the channels automatically using a programmable prescaler. It feeds time-multiplexed consumers such as display digit scanning and bus monitors. It is the clocked successor to the fixed 8x8 combinational mux.

Parameters:
WIDTH, 8, data bits per channel
CH, 8, number of input channels (2..16, any value, not required to be a power of two)
SEL_W, 3, select width; must satisfy 2**SEL_W >= CH
DIV, 4, scan dwell in clock cycles per channel (>=1)
DIV_W, 16, prescaler counter width; must satisfy 2**DIV_W > DIV

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
mode  in  1  0 = manual, 1 = scan
sel  in  SEL_W  manual channel select
hold  in  1  scan mode only: freeze prescaler and channel
din  in  CH*WIDTH  flattened channel inputs; channel k = din[k*WIDTH +: WIDTH]
o  out  WIDTH  registered selected data
cur_sel  out  SEL_W  currently selected channel (registered)
tick  out  1  one-cycle pulse in the cycle cur_sel advances in scan mode
sel_err  out  1  registered; 1 when manual sel >= CH

Behaviour:
- Reset (rst=1 at an edge): cur_sel=0, div_cnt=0, o=0, tick=0, sel_err=0. Reset has priority over every other input and is legal mid-scan.
- Manual mode (mode=0), each edge:
  - div_cnt <= 0; tick <= 0.
  - If sel < CH: cur_sel <= sel, sel_err <= 0.
  - Otherwise: cur_sel holds its value and sel_err <= 1.
- Scan mode (mode=1), each edge:
  - sel_err <= 0.
  - If hold=1: div_cnt, cur_sel hold; tick <= 0.
  - Else if div_cnt == DIV-1: div_cnt <= 0, tick <= 1, cur_sel <= (cur_sel == CH-1) ? 0 : cur_sel+1.
  - Else: div_cnt <= div_cnt+1, tick <= 0.
  - Wrap happens at CH-1, not at 2**SEL_W-1.
- Output: o <= din channel indexed by the registered cur_sel. Latency from a sel or cur_sel change to o is one edge after cur_sel updates, i.e. 2 edges from sel change to o.
- din changes with cur_sel fixed: o reflects the new data after 1 edge.
- Mode switch manual->scan: scanning starts from the current cur_sel with div_cnt=0. First advance occurs DIV edges later.
- Mode switch scan->manual: takes effect on the next edge; sel overrides cur_sel immediately.
- DIV=1: cur_sel advances every edge and tick is held high continuously while scanning without hold.
- hold and terminal count in the same cycle: hold wins, no advance.
- CH=1 special case: cur_sel stays 0 and tick still pulses every DIV cycles.

Optional Feature:
Macro MUX_SCAN_ONEHOT_EN.
- When defined: adds output port an [CH-1:0], registered, active-low one-hot of cur_sel (an[cur_sel]=0, all other bits 1), updated on the same edge as o. Reset value is all ones except bit 0, which is 0.
- When undefined: port an is absent and no extra logic is generated.

Decomposition:
- Package mux_scan_pkg holds:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1 constants;
  - a clog2 function used to check SEL_W;
  - an elaboration-time assertion macro for CH <= 2**SEL_W and DIV < 2**DIV_W.
- One natural sub-module, scan_prescaler: owns div_cnt and produces the terminal-count strobe, with inputs clk, rst, clr (manual mode) and hold.
- The top level holds the channel register, output mux register and sel_err.

Test Plan:
- Inputs for all scenarios: CH=8, DIV=4, channel k = 8'hkk (00, 11 … 77).
  - Reset, then mode=0, sel=5 → cur_sel=5 after 1 edge, o=8'h55 after 2 edges, sel_err=0.
  - Manual sweep sel=0..7, each held 5 cycles → o steps 00,11,…,77, each value appearing exactly 2 edges after its sel change.
  - mode=1, hold=0 from cur_sel=0 → tick every 4th cycle; cur_sel 0,1,…,7,0; o=8'h77 is followed by 8'h00 (wrap).
- Scan with hold=1 asserted for 10 cycles while div_cnt=3 → no tick and cur_sel unchanged; advance occurs on the first edge after hold drops.
- Rebuild with CH=6, SEL_W=3:
  - scan wraps 5→0, o never 8'h66/77;
  - manual sel=6 → sel_err=1 and o keeps the previous value.
- Assert rst for 1 cycle mid-scan at cur_sel=4 → next cycle cur_sel=0, o=0, tick=0, and scan restarts with the first tick 4 cycles later. With MUX_SCAN_ONEHOT_EN defined, an=8'hFE after reset and 8'hDF when cur_sel=5.
